// File: rtl/pipe_stage_buffer.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-bubble and an
// optional skid entry that lets in_ready come straight from a flop.
module pipe_stage_buffer #(
  parameter int CTRL_W  = 16,
  parameter int DATA_W  = 72,
  parameter int SKID_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  logic [CTRL_W-1:0] main_ctrl_reg, main_ctrl_next;
  logic [DATA_W-1:0] main_data_reg, main_data_next;
  logic              transfer;
  logic              pop;

  assign transfer = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign out_data = main_data_reg;

  // Control bits collapse to NOP whenever no valid instruction is presented.
  genvar gi;
  generate
    for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_mask
      assign out_ctrl[gi] = main_ctrl_reg[gi] & out_valid;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      main_ctrl_reg <= '0;
      main_data_reg <= '0;
    end else begin
      main_ctrl_reg <= main_ctrl_next;
      main_data_reg <= main_data_next;
    end
  end

  generate
    if (SKID_EN == 0) begin : g_single
      logic valid_reg, valid_next;

      always_comb begin
        valid_next     = valid_reg;
        main_ctrl_next = main_ctrl_reg;
        main_data_next = main_data_reg;
        if (flush) begin
          valid_next = 1'b0;
        end else if (transfer) begin
          valid_next     = 1'b1;
          main_ctrl_next = in_ctrl;
          main_data_next = in_data;
        end else if (pop) begin
          valid_next = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
        end else begin
          valid_reg <= valid_next;
        end
      end

      // The only combinational path through the block: out_ready -> in_ready.
      assign in_ready  = ~valid_reg | out_ready;
      assign out_valid = valid_reg;
      assign occupancy = {1'b0, valid_reg};

    end else begin : g_skid
      state_t            state_reg, state_next;
      logic              in_ready_reg, in_ready_next;
      logic [CTRL_W-1:0] skid_ctrl_reg, skid_ctrl_next;
      logic [DATA_W-1:0] skid_data_reg, skid_data_next;

      always_comb begin
        state_next     = state_reg;
        main_ctrl_next = main_ctrl_reg;
        main_data_next = main_data_reg;
        skid_ctrl_next = skid_ctrl_reg;
        skid_data_next = skid_data_reg;
        case (state_reg)
          EMPTY: begin
            if (transfer) begin
              state_next     = ONE;
              main_ctrl_next = in_ctrl;
              main_data_next = in_data;
            end
          end
          ONE: begin
            if (transfer && pop) begin
              main_ctrl_next = in_ctrl;
              main_data_next = in_data;
            end else if (transfer) begin
              state_next     = FULL;
              skid_ctrl_next = in_ctrl;
              skid_data_next = in_data;
            end else if (pop) begin
              state_next = EMPTY;
            end
          end
          FULL: begin
            // in_ready is low here, so the skid (younger) entry simply moves up.
            if (pop) begin
              state_next     = ONE;
              main_ctrl_next = skid_ctrl_reg;
              main_data_next = skid_data_reg;
            end
          end
          default: begin
            state_next = EMPTY;
          end
        endcase
        // Flush drops everything, including this cycle's input; out_data keeps its value.
        if (flush) begin
          state_next     = EMPTY;
          main_ctrl_next = main_ctrl_reg;
          main_data_next = main_data_reg;
        end
        in_ready_next = (state_next != FULL);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg     <= EMPTY;
          in_ready_reg  <= 1'b1;
          skid_ctrl_reg <= '0;
          skid_data_reg <= '0;
        end else begin
          state_reg     <= state_next;
          in_ready_reg  <= in_ready_next;
          skid_ctrl_reg <= skid_ctrl_next;
          skid_data_reg <= skid_data_next;
        end
      end

      assign in_ready  = in_ready_reg;
      assign out_valid = (state_reg != EMPTY);
      assign occupancy = state_reg;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: one skid instance and one single-entry instance share
// the same stimulus; directed scenarios plus a randomized run against queue models.
module tb_pipe_stage_buffer;
  localparam int CW = 16;
  localparam int DW = 72;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, out_ready, flush;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          rdy1, ov1, rdy0, ov0;
  logic [CW-1:0] oc1, oc0;
  logic [DW-1:0] od1, od0;
  logic [1:0]    occ1, occ0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CW+DW-1:0] q1[$];
  logic [CW+DW-1:0] q0[$];

  always #5 clk = ~clk;

  pipe_stage_buffer #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_ctrl(in_ctrl),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1),
    .out_data(od1), .flush(flush), .occupancy(occ1)
  );

  pipe_stage_buffer #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_ctrl(in_ctrl),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0),
    .out_data(od0), .flush(flush), .occupancy(occ0)
  );

  function automatic logic [DW-1:0] mkdata(input logic [CW-1:0] c);
    return {c[7:0], 32'hC0DE_0000 ^ {16'h0, c}, 32'h1234_5678 + {16'h0, c}};
  endfunction

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic ordy, input logic fl);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = mkdata(c);
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 16'hAA, 1'b1, 1'b0);
    step();
    step();
    rst = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({ov1, occ1, rdy1} !== {1'b0, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_status_skid: got ov=%b occ=%0d rdy=%b, want 0 0 1", ov1, occ1, rdy1);
    end
    n_checks++;
    if (oc1 !== '0 || od1 !== '0) begin
      n_fail++;
      $display("FAIL reset_out_skid: got ctrl=%h data=%h, want 0 0", oc1, od1);
    end
    n_checks++;
    if ({ov0, occ0, rdy0} !== {1'b0, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_status_single: got ov=%b occ=%0d rdy=%b, want 0 0 1", ov0, occ0, rdy0);
    end
    n_checks++;
    if (oc0 !== '0 || od0 !== '0) begin
      n_fail++;
      $display("FAIL reset_out_single: got ctrl=%h data=%h, want 0 0", oc0, od0);
    end
    step();
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      if (i <= 8) drive(1'b1, CW'(i), 1'b1, 1'b0);
      else        drive(1'b0, 16'h0, 1'b1, 1'b0);
      @(negedge clk);
      if (i >= 2 && i <= 9) begin
        n_checks++;
        if ({ov1, occ1, oc1, od1} !== {1'b1, 2'd1, CW'(i - 1), mkdata(CW'(i - 1))}) begin
          n_fail++;
          $display("FAIL stream_skid[%0d]: got ov=%b occ=%0d ctrl=%h, want 1 1 %h", i, ov1, occ1, oc1, CW'(i - 1));
        end
        n_checks++;
        if ({ov0, occ0, oc0, od0} !== {1'b1, 2'd1, CW'(i - 1), mkdata(CW'(i - 1))}) begin
          n_fail++;
          $display("FAIL stream_single[%0d]: got ov=%b occ=%0d ctrl=%h, want 1 1 %h", i, ov0, occ0, oc0, CW'(i - 1));
        end
      end else begin
        n_checks++;
        if ({ov1, occ1, oc1, ov0, occ0, oc0} !== '0) begin
          n_fail++;
          $display("FAIL stream_empty[%0d]: got ov1=%b occ1=%0d ov0=%b occ0=%0d, want all 0", i, ov1, occ1, ov0, occ0);
        end
      end
      if (i <= 8) begin
        n_checks++;
        if ({rdy1, rdy0} !== 2'b11) begin
          n_fail++;
          $display("FAIL stream_ready[%0d]: got rdy1=%b rdy0=%b, want 1 1", i, rdy1, rdy0);
        end
      end
      step();
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive(1'b1, 16'h11, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (rdy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_accept_a: got rdy=%b, want 1", rdy1);
    end
    step();
    drive(1'b1, 16'h22, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({rdy1, ov1, occ1, oc1} !== {1'b1, 1'b1, 2'd1, 16'h11}) begin
      n_fail++;
      $display("FAIL stall_accept_b: got rdy=%b ov=%b occ=%0d ctrl=%h, want 1 1 1 0011", rdy1, ov1, occ1, oc1);
    end
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 16'h44, 1'b0, 1'b0);
      @(negedge clk);
      n_checks++;
      if ({rdy1, ov1, occ1, oc1, od1} !== {1'b0, 1'b1, 2'd2, 16'h11, mkdata(16'h11)}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got rdy=%b ov=%b occ=%0d ctrl=%h, want 0 1 2 0011", k, rdy1, ov1, occ1, oc1);
      end
      step();
    end
    drive(1'b1, 16'h44, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({rdy1, occ1, oc1} !== {1'b0, 2'd2, 16'h11}) begin
      n_fail++;
      $display("FAIL stall_pop_a: got rdy=%b occ=%0d ctrl=%h, want 0 2 0011", rdy1, occ1, oc1);
    end
    step();
    drive(1'b1, 16'h44, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({rdy1, occ1, oc1, od1} !== {1'b1, 2'd1, 16'h22, mkdata(16'h22)}) begin
      n_fail++;
      $display("FAIL stall_pop_b: got rdy=%b occ=%0d ctrl=%h, want 1 1 0022", rdy1, occ1, oc1);
    end
    step();
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({ov1, occ1, oc1, od1} !== {1'b1, 2'd1, 16'h44, mkdata(16'h44)}) begin
      n_fail++;
      $display("FAIL stall_pop_c: got ov=%b occ=%0d ctrl=%h, want 1 1 0044", ov1, occ1, oc1);
    end
    step();
    @(negedge clk);
    n_checks++;
    if ({ov1, occ1, oc1} !== '0) begin
      n_fail++;
      $display("FAIL stall_drained: got ov=%b occ=%0d ctrl=%h, want 0 0 0000", ov1, occ1, oc1);
    end
    step();
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 16'h51, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h52, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h33, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({occ1, occ0} !== {2'd2, 2'd1}) begin
      n_fail++;
      $display("FAIL flush_pre: got occ1=%0d occ0=%0d, want 2 1", occ1, occ0);
    end
    step();
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({ov1, occ1, oc1, rdy1} !== {1'b0, 2'd0, 16'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL flush_skid: got ov=%b occ=%0d ctrl=%h rdy=%b, want 0 0 0000 1", ov1, occ1, oc1, rdy1);
    end
    n_checks++;
    if ({od1, od0} !== {mkdata(16'h51), mkdata(16'h51)}) begin
      n_fail++;
      $display("FAIL flush_data_hold: got od1=%h od0=%h, want %h", od1, od0, mkdata(16'h51));
    end
    n_checks++;
    if ({ov0, occ0, oc0} !== '0) begin
      n_fail++;
      $display("FAIL flush_single: got ov=%b occ=%0d ctrl=%h, want 0 0 0000", ov0, occ0, oc0);
    end
    step();
    @(negedge clk);
    n_checks++;
    if ({ov1, ov0} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_dropped_input: got ov1=%b ctrl1=%h ov0=%b, want 0 0000 0", ov1, oc1, ov0);
    end
    step();
    drive(1'b1, 16'h61, 1'b1, 1'b0);
    step();
    drive(1'b0, 16'h0, 1'b1, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({ov1, oc1, ov0, oc0} !== {1'b1, 16'h61, 1'b1, 16'h61}) begin
      n_fail++;
      $display("FAIL flush_pop_pre: got ov1=%b ctrl1=%h ov0=%b ctrl0=%h, want 1 0061 1 0061", ov1, oc1, ov0, oc0);
    end
    step();
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({ov1, occ1, oc1, ov0, occ0, oc0} !== '0) begin
      n_fail++;
      $display("FAIL flush_pop_no_repeat: got ov1=%b ctrl1=%h ov0=%b ctrl0=%h, want all 0", ov1, oc1, ov0, oc0);
    end
    step();
  endtask

  task automatic test_skidless();
    do_reset();
    drive(1'b1, 16'h71, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++;
    if (rdy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL single_accept: got rdy=%b, want 1", rdy0);
    end
    step();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 16'h72, 1'b0, 1'b0);
      @(negedge clk);
      n_checks++;
      if ({ov0, rdy0, oc0} !== {1'b1, 1'b0, 16'h71}) begin
        n_fail++;
        $display("FAIL single_stall[%0d]: got ov=%b rdy=%b ctrl=%h, want 1 0 0071", k, ov0, rdy0, oc0);
      end
      if (k == 0) step();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (rdy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready_release: got rdy=%b, want 1", rdy0);
    end
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({ov0, occ0, oc0, od0, rdy0} !== {1'b1, 2'd1, 16'h72, mkdata(16'h72), 1'b0}) begin
      n_fail++;
      $display("FAIL single_replaced: got ov=%b occ=%0d ctrl=%h rdy=%b, want 1 1 0072 0", ov0, occ0, oc0, rdy0);
    end
    step();
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    step();
    @(negedge clk);
    n_checks++;
    if ({ov0, oc0} !== '0) begin
      n_fail++;
      $display("FAIL single_drained: got ov=%b ctrl=%h, want 0 0000", ov0, oc0);
    end
    step();
  endtask

  task automatic test_flush_rst();
    do_reset();
    drive(1'b1, 16'h81, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h82, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    drive(1'b1, 16'h99, 1'b0, 1'b1);
    step();
    rst = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({ov1, occ1, rdy1, oc1, od1} !== {1'b0, 2'd0, 1'b1, 16'h0, 72'h0}) begin
      n_fail++;
      $display("FAIL flush_rst_skid: got ov=%b occ=%0d rdy=%b ctrl=%h data=%h, want 0 0 1 0 0", ov1, occ1, rdy1, oc1, od1);
    end
    n_checks++;
    if ({ov0, occ0, rdy0, oc0, od0} !== {1'b0, 2'd0, 1'b1, 16'h0, 72'h0}) begin
      n_fail++;
      $display("FAIL flush_rst_single: got ov=%b occ=%0d rdy=%b ctrl=%h data=%h, want 0 0 1 0 0", ov0, occ0, rdy0, oc0, od0);
    end
    step();
  endtask

  task automatic test_random();
    logic v, r, f, rs, er1, er0, bad;
    logic [CW+DW-1:0] tmp;
    do_reset();
    q1.delete();
    q0.delete();
    for (int cyc = 0; cyc < 10000 && n_fail < 50; cyc++) begin
      v  = ($urandom_range(3) != 0);
      r  = ($urandom_range(9) < 7);
      f  = ($urandom_range(63) == 0);
      rs = ($urandom_range(499) == 0);
      rst       = rs;
      in_valid  = v;
      in_ctrl   = CW'($urandom);
      in_data   = {8'($urandom), $urandom, $urandom};
      out_ready = r;
      flush     = f;
      @(negedge clk);
      er1 = (q1.size() < 2);
      er0 = (q0.size() == 0) || r;
      n_checks++;
      if ({ov1, occ1, rdy1} !== {q1.size() != 0, 2'(q1.size()), er1}) begin
        n_fail++;
        $display("FAIL rand_status_skid[%0d]: got ov=%b occ=%0d rdy=%b, want %b %0d %b", cyc, ov1, occ1, rdy1, q1.size() != 0, q1.size(), er1);
      end
      if (q1.size() != 0) bad = ({oc1, od1} !== q1[0]);
      else                bad = (oc1 !== '0);
      n_checks++;
      if (bad) begin
        n_fail++;
        $display("FAIL rand_out_skid[%0d]: got ctrl=%h data=%h, want %h", cyc, oc1, od1, (q1.size() != 0) ? q1[0] : '0);
      end
      n_checks++;
      if ({ov0, occ0, rdy0} !== {q0.size() != 0, 2'(q0.size()), er0}) begin
        n_fail++;
        $display("FAIL rand_status_single[%0d]: got ov=%b occ=%0d rdy=%b, want %b %0d %b", cyc, ov0, occ0, rdy0, q0.size() != 0, q0.size(), er0);
      end
      if (q0.size() != 0) bad = ({oc0, od0} !== q0[0]);
      else                bad = (oc0 !== '0);
      n_checks++;
      if (bad) begin
        n_fail++;
        $display("FAIL rand_out_single[%0d]: got ctrl=%h data=%h, want %h", cyc, oc0, od0, (q0.size() != 0) ? q0[0] : '0);
      end
      if (rs) begin
        q1.delete();
        q0.delete();
      end else begin
        if (q1.size() != 0 && r) tmp = q1.pop_front();
        if (v && er1) q1.push_back({in_ctrl, in_data});
        if (f) q1.delete();
        if (q0.size() != 0 && r) tmp = q0.pop_front();
        if (v && er0) q0.push_back({in_ctrl, in_data});
        if (f) q0.delete();
      end
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_skidless();
    test_flush_rst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
